mem_read_sequencer: RTL and testbench

Read-side sequencer for the team's 4-entry scratch memory. The memory is filled by the existing write-address FSM. This block walks the same addresses in order 0→1→2→3 and issues one read per entry. It registers each returned word and presents it downstream on a valid/ready handshake, for example to the display driver. It supports a single-pass mode and a continuous-loop mode, and can be aborted at any time.

---
 rtl/mem_seq_pkg.sv | 22 ++
 rtl/mem_read_addr_counter.sv | 39 +++
 rtl/mem_read_sequencer.sv | 118 +++++++++++
 tb/tb_mem_read_sequencer.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_seq_pkg.sv
// Shared definitions for the scratch-memory read/write sequencers.
// State encodings and default geometry of the 4-entry scratch memory.
package mem_seq_pkg;

   localparam int DEPTH_DEF  = 4;
   localparam int ADDR_W_DEF = 2;

   localparam logic [2:0] ST_IDLE    = 3'd0;
   localparam logic [2:0] ST_ISSUE   = 3'd1;
   localparam logic [2:0] ST_CAPTURE = 3'd2;
   localparam logic [2:0] ST_PRESENT = 3'd3;
   localparam logic [2:0] ST_FINISH  = 3'd4;

   typedef enum logic [2:0] {
      IDLE    = ST_IDLE,
      ISSUE   = ST_ISSUE,
      CAPTURE = ST_CAPTURE,
      PRESENT = ST_PRESENT,
      FINISH  = ST_FINISH
   } rd_state_e;

endpackage

// File: rtl/mem_read_addr_counter.sv
// Read address counter with clear, increment and a last-entry flag.
// Wrap past DEPTH-1 is the natural ADDR_W-bit overflow.
module mem_read_addr_counter
   import mem_seq_pkg::*;
#(
   parameter int DEPTH  = DEPTH_DEF,
   parameter int ADDR_W = ADDR_W_DEF
) (
   input  logic              clk_i,
   input  logic              rst_ni,
   input  logic              clr_i,
   input  logic              inc_i,
   output logic [ADDR_W-1:0] addr_o,
   output logic              last_o
);

   logic [ADDR_W-1:0] addr_q, addr_d;

   always_comb begin
      addr_d = addr_q;
      if (clr_i) begin
         addr_d = '0;
      end else if (inc_i) begin
         addr_d = addr_q + 1'b1;
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         addr_q <= '0;
      end else begin
         addr_q <= addr_d;
      end
   end

   assign addr_o = addr_q;
   assign last_o = (addr_q == ADDR_W'(DEPTH - 1));

endmodule

// File: rtl/mem_read_sequencer.sv
// Walks the scratch memory in address order, one read per entry,
// and presents each returned word on a valid/ready handshake.
module mem_read_sequencer
   import mem_seq_pkg::*;
#(
   parameter int DATA_W = 4,
   parameter int DEPTH  = DEPTH_DEF,
   parameter int ADDR_W = ADDR_W_DEF
) (
   input  logic              Clock,
   input  logic              Reset,
   input  logic              Start,
   input  logic              Loop,
   input  logic              Stop,
   input  logic [DATA_W-1:0] ReadData,
   input  logic              Ready,
   output logic              ReadEn,
   output logic [ADDR_W-1:0] ReadAddr,
   output logic [DATA_W-1:0] OutData,
   output logic [ADDR_W-1:0] OutIndex,
   output logic              OutValid,
   output logic              Busy,
   output logic              Done
);

   rd_state_e         state_q, state_d;
   logic              loop_q, loop_d;
   logic [DATA_W-1:0] data_q;
   logic [ADDR_W-1:0] idx_q;
   logic [ADDR_W-1:0] addr;
   logic              last;
   logic              clr;
   logic              inc;
   logic              cap;

   mem_read_addr_counter #(
      .DEPTH  (DEPTH),
      .ADDR_W (ADDR_W)
   ) u_addr (
      .clk_i  (Clock),
      .rst_ni (Reset),
      .clr_i  (clr),
      .inc_i  (inc),
      .addr_o (addr),
      .last_o (last)
   );

   always_comb begin
      state_d = state_q;
      loop_d  = loop_q;
      clr     = 1'b0;
      inc     = 1'b0;
      cap     = 1'b0;
      if (Stop) begin
         state_d = IDLE;
         clr     = 1'b1;
      end else begin
         unique case (state_q)
            IDLE: begin
               if (Start) begin
                  loop_d  = Loop;
                  clr     = 1'b1;
                  state_d = ISSUE;
               end
            end
            ISSUE: begin
               state_d = CAPTURE;
            end
            CAPTURE: begin
               cap     = 1'b1;
               state_d = PRESENT;
            end
            PRESENT: begin
               if (Ready) begin
                  // last entry either wraps (loop mode) or ends the pass
                  if (!last || loop_q) begin
                     inc     = 1'b1;
                     state_d = ISSUE;
                  end else begin
                     state_d = FINISH;
                  end
               end
            end
            FINISH: begin
               state_d = IDLE;
            end
            default: begin
               state_d = IDLE;
            end
         endcase
      end
   end

   always_ff @(posedge Clock or negedge Reset) begin
      if (!Reset) begin
         state_q <= IDLE;
         loop_q  <= 1'b0;
         data_q  <= '0;
         idx_q   <= '0;
      end else begin
         state_q <= state_d;
         loop_q  <= loop_d;
         if (cap) begin
            data_q <= ReadData;
            idx_q  <= addr;
         end
      end
   end

   assign ReadEn   = (state_q == ISSUE);
   assign ReadAddr = ReadEn ? addr : '0;
   assign OutData  = data_q;
   assign OutIndex = idx_q;
   assign OutValid = (state_q == PRESENT);
   assign Busy     = (state_q != IDLE);
   assign Done     = (state_q == FINISH);

endmodule

// File: tb/tb_mem_read_sequencer.sv
// Directed bench for mem_read_sequencer: vector table for a single
// pass plus hand-written backpressure, loop, stop and reset cases.
module tb_mem_read_sequencer;

   logic       Clock;
   logic       Reset;
   logic       Start;
   logic       Loop;
   logic       Stop;
   logic [3:0] ReadData;
   logic       Ready;
   logic       ReadEn;
   logic [1:0] ReadAddr;
   logic [3:0] OutData;
   logic [1:0] OutIndex;
   logic       OutValid;
   logic       Busy;
   logic       Done;

   int total;
   int bad;

   logic [3:0] mem [4];

   mem_read_sequencer #(
      .DATA_W (4),
      .DEPTH  (4),
      .ADDR_W (2)
   ) dut (
      .Clock    (Clock),
      .Reset    (Reset),
      .Start    (Start),
      .Loop     (Loop),
      .Stop     (Stop),
      .ReadData (ReadData),
      .Ready    (Ready),
      .ReadEn   (ReadEn),
      .ReadAddr (ReadAddr),
      .OutData  (OutData),
      .OutIndex (OutIndex),
      .OutValid (OutValid),
      .Busy     (Busy),
      .Done     (Done)
   );

   initial Clock = 1'b0;
   always #5 Clock = ~Clock;

   // memory: word valid the cycle after the read strobe
   always @(posedge Clock) begin
      if (ReadEn) ReadData <= mem[ReadAddr];
   end

   typedef struct {
      logic       start;
      logic       ready;
      logic       e_en;
      logic [1:0] e_addr;
      logic       e_val;
      logic [3:0] e_data;
      logic [1:0] e_idx;
      logic       e_busy;
      logic       e_done;
   } vec_t;

   vec_t tbl [15];

   function automatic vec_t mk(logic st, logic rd, logic en,
                               logic [1:0] ad, logic vl,
                               logic [3:0] dt, logic [1:0] ix,
                               logic bz, logic dn);
      vec_t v;
      v.start = st; v.ready = rd; v.e_en = en; v.e_addr = ad;
      v.e_val = vl; v.e_data = dt; v.e_idx = ix;
      v.e_busy = bz; v.e_done = dn;
      return v;
   endfunction

   task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
      end
   endtask

   task automatic step(int n = 1);
      for (int i = 0; i < n; i++) begin
         @(posedge Clock);
         #1;
      end
   endtask

   task automatic chk_zero(string nm);
      chk({nm, ".ReadEn"},   32'(ReadEn),   0);
      chk({nm, ".ReadAddr"}, 32'(ReadAddr), 0);
      chk({nm, ".OutData"},  32'(OutData),  0);
      chk({nm, ".OutIndex"}, 32'(OutIndex), 0);
      chk({nm, ".OutValid"}, 32'(OutValid), 0);
      chk({nm, ".Busy"},     32'(Busy),     0);
      chk({nm, ".Done"},     32'(Done),     0);
   endtask

   task automatic chk_word(string nm, logic [3:0] d, logic [1:0] ix);
      chk({nm, ".valid"}, 32'(OutValid), 1);
      chk({nm, ".data"},  32'(OutData),  32'(d));
      chk({nm, ".index"}, 32'(OutIndex), 32'(ix));
   endtask

   task automatic chk_issue(string nm, logic [1:0] ad);
      chk({nm, ".en"},   32'(ReadEn),   1);
      chk({nm, ".addr"}, 32'(ReadAddr), 32'(ad));
   endtask

   task automatic steps_nodone(string nm, int n);
      for (int i = 0; i < n; i++) begin
         step();
         chk({nm, ".done"}, 32'(Done), 0);
      end
   endtask

   initial begin
      total = 0;
      bad   = 0;
      mem[0] = 4'hA; mem[1] = 4'h5; mem[2] = 4'h3; mem[3] = 4'hC;
      ReadData = '0;
      Reset = 1'b0;
      Start = 1'b0;
      Loop  = 1'b0;
      Stop  = 1'b0;
      Ready = 1'b1;

      tbl[0]  = mk(1, 1, 0, 0, 0, 4'h0, 0, 0, 0);
      tbl[1]  = mk(0, 1, 1, 0, 0, 4'h0, 0, 1, 0);
      tbl[2]  = mk(0, 1, 0, 0, 0, 4'h0, 0, 1, 0);
      tbl[3]  = mk(0, 1, 0, 0, 1, 4'hA, 0, 1, 0);
      tbl[4]  = mk(0, 1, 1, 1, 0, 4'h0, 0, 1, 0);
      tbl[5]  = mk(0, 1, 0, 0, 0, 4'h0, 0, 1, 0);
      tbl[6]  = mk(0, 1, 0, 0, 1, 4'h5, 1, 1, 0);
      tbl[7]  = mk(0, 1, 1, 2, 0, 4'h0, 0, 1, 0);
      tbl[8]  = mk(0, 1, 0, 0, 0, 4'h0, 0, 1, 0);
      tbl[9]  = mk(0, 1, 0, 0, 1, 4'h3, 2, 1, 0);
      tbl[10] = mk(0, 1, 1, 3, 0, 4'h0, 0, 1, 0);
      tbl[11] = mk(0, 1, 0, 0, 0, 4'h0, 0, 1, 0);
      tbl[12] = mk(0, 1, 0, 0, 1, 4'hC, 3, 1, 0);
      tbl[13] = mk(0, 1, 0, 0, 0, 4'h0, 0, 1, 1);
      tbl[14] = mk(0, 1, 0, 0, 0, 4'h0, 0, 0, 0);

      #12;
      chk_zero("reset");
      Reset = 1'b1;
      step();

      // single pass, Ready held high
      for (int c = 0; c < 15; c++) begin
         Start = tbl[c].start;
         Ready = tbl[c].ready;
         chk($sformatf("pass.c%0d.en", c),    32'(ReadEn),   32'(tbl[c].e_en));
         chk($sformatf("pass.c%0d.addr", c),  32'(ReadAddr), 32'(tbl[c].e_addr));
         chk($sformatf("pass.c%0d.valid", c), 32'(OutValid), 32'(tbl[c].e_val));
         chk($sformatf("pass.c%0d.busy", c),  32'(Busy),     32'(tbl[c].e_busy));
         chk($sformatf("pass.c%0d.done", c),  32'(Done),     32'(tbl[c].e_done));
         if (tbl[c].e_val) begin
            chk($sformatf("pass.c%0d.data", c),  32'(OutData),  32'(tbl[c].e_data));
            chk($sformatf("pass.c%0d.index", c), 32'(OutIndex), 32'(tbl[c].e_idx));
         end
         step();
         Start = 1'b0;
      end

      // backpressure on word 1
      Start = 1'b1; Loop = 1'b0; Ready = 1'b1;
      step();
      Start = 1'b0;
      step(5);
      chk_word("bp.w1", 4'h5, 1);
      Ready = 1'b0;
      for (int i = 0; i < 5; i++) begin
         step();
         chk_word($sformatf("bp.hold%0d", i), 4'h5, 1);
         chk($sformatf("bp.hold%0d.en", i), 32'(ReadEn), 0);
      end
      Ready = 1'b1;
      step();
      chk_issue("bp.iss2", 2);
      step(2);
      chk_word("bp.w2", 4'h3, 2);
      step(3);
      chk_word("bp.w3", 4'hC, 3);
      step();
      chk("bp.done", 32'(Done), 1);
      step();
      chk("bp.idle", 32'(Busy), 0);

      // loop mode, stop in second pass
      Start = 1'b1; Loop = 1'b1;
      step();
      Start = 1'b0; Loop = 1'b0;
      steps_nodone("loop.p1", 11);
      chk_word("loop.w3", 4'hC, 3);
      step();
      chk_issue("loop.wrap", 0);
      steps_nodone("loop.p2a", 2);
      chk_word("loop.w0b", 4'hA, 0);
      steps_nodone("loop.p2b", 3);
      chk_word("loop.w1b", 4'h5, 1);
      Stop = 1'b1;
      step();
      Stop = 1'b0;
      chk("loop.stop.busy",  32'(Busy),     0);
      chk("loop.stop.valid", 32'(OutValid), 0);
      chk("loop.stop.done",  32'(Done),     0);
      steps_nodone("loop.after", 3);
      chk("loop.after.busy", 32'(Busy), 0);

      // Start together with Stop in IDLE
      Start = 1'b1; Stop = 1'b1;
      step();
      Start = 1'b0; Stop = 1'b0;
      chk("ss.busy1", 32'(Busy), 0);
      step();
      chk("ss.busy2", 32'(Busy), 0);

      // Start during PRESENT is ignored
      Start = 1'b1;
      step();
      Start = 1'b0;
      step(2);
      chk_word("sp.w0", 4'hA, 0);
      Ready = 1'b0; Start = 1'b1; Loop = 1'b1;
      step();
      Start = 1'b0; Loop = 1'b0;
      chk_word("sp.held", 4'hA, 0);
      Ready = 1'b1;
      step();
      chk_issue("sp.iss1", 1);
      step(2);
      chk_word("sp.w1", 4'h5, 1);
      Stop = 1'b1;
      step();
      Stop = 1'b0;
      chk("sp.stop.busy", 32'(Busy), 0);

      // async reset during CAPTURE of word 1
      Start = 1'b1;
      step();
      Start = 1'b0;
      step(4);
      chk("rst.pre.busy", 32'(Busy), 1);
      chk("rst.pre.data", 32'(OutData), 32'hA);
      #2;
      Reset = 1'b0;
      #1;
      chk_zero("rst.async");
      #3;
      Reset = 1'b1;
      step();
      chk_zero("rst.release");
      Start = 1'b1;
      step();
      Start = 1'b0;
      chk_issue("rst.restart", 0);
      step(2);
      chk_word("rst.w0", 4'hA, 0);
      step(10);
      chk("rst.fin.done", 32'(Done), 1);
      step();
      chk("rst.fin.busy", 32'(Busy), 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
